// File: rtl/pb_prog_loader_pkg.sv
// Shared types and constants for the PicoBlaze serial program loader.
package pb_prog_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    CHK
  } state_t;

  localparam logic [1:0] B0 = 2'd0;
  localparam logic [1:0] B1 = 2'd1;
  localparam logic [1:0] B2 = 2'd2;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/pb_loader_timeout.sv
// Inter-byte idle counter; expire pulses during the TIMEOUT_CYCLES-th consecutive idle cycle.
module pb_loader_timeout #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      logic unused_tmo;
      assign unused_tmo = ^{clk, reset, clr, en};
      assign expire     = 1'b0;
    end else begin : g_on
      localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
      logic [CNT_W-1:0] cnt;

      always_ff @(posedge clk) begin
        if (reset || clr) begin
          cnt <= '0;
        end else if (en) begin
          cnt <= cnt + CNT_W'(1);
        end
      end

      // Combinational so the loader leaves the frame on the edge closing this idle cycle.
      assign expire = en && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    end
  endgenerate

endmodule

// File: rtl/pb_prog_loader.sv
// Framed byte-stream loader writing 18-bit PicoBlaze instructions into program RAM port B.
module pb_prog_loader
  import pb_prog_loader_pkg::*;
#(
  parameter int         ADDR_W         = 10,
  parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [17:0]       mem_din,
  output logic              mem_we,
  output logic              cpu_reset,
  output logic              load_ok,
  output logic              load_err
);

  localparam int DEPTH = 2 ** ADDR_W;

  state_t      state;
  state_t      state_nxt;
  logic        accept;
  logic [7:0]  sum;
  logic [7:0]  sum_nxt;
  logic [7:0]  len_hi;
  logic [15:0] len;
  logic [15:0] len_full;
  logic [15:0] word_cnt;
  logic [1:0]  byte_idx;
  logic [1:0]  b0_hold;
  logic [7:0]  b1_hold;
  logic        addr_inc_p1;
  logic        start;
  logic        len_bad;
  logic        wr_word;
  logic        last_word;
  logic        chk_good;
  logic        chk_bad;
  logic        tmo_expire;

  function automatic logic [7:0] sum_add(input logic [7:0] acc, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, acc} + {1'b0, b};
    return s[7:0];
  endfunction

  assign accept = rx_valid && rx_ready;

  pb_loader_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (clk),
    .reset (reset),
    .clr   (accept || (state == IDLE)),
    .en    ((state != IDLE) && !accept),
    .expire(tmo_expire)
  );

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    len_bad   = 1'b0;
    wr_word   = 1'b0;
    chk_good  = 1'b0;
    chk_bad   = 1'b0;
    len_full  = {len_hi, rx_data};
    last_word = (word_cnt == (len - 16'd1));
    sum_nxt   = sum_add(sum, rx_data);
    if (tmo_expire) begin
      state_nxt = IDLE;
    end else if (accept) begin
      case (state)
        IDLE: begin
          if (rx_data == SYNC_BYTE) begin
            state_nxt = LEN_HI;
            start     = 1'b1;
          end
        end
        LEN_HI: state_nxt = LEN_LO;
        LEN_LO: begin
          if ((len_full == 16'd0) || ({1'b0, len_full} > 17'(DEPTH))) begin
            state_nxt = IDLE;
            len_bad   = 1'b1;
          end else begin
            state_nxt = DATA;
          end
        end
        DATA: begin
          if (byte_idx == B2) begin
            wr_word = 1'b1;
            if (last_word) state_nxt = CHK;
          end
        end
        CHK: begin
          state_nxt = IDLE;
          if (sum_nxt == 8'h00) chk_good = 1'b1;
          else                  chk_bad  = 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Stage p0 -> p1: control state, write strobe and registered write word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rx_ready    <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_din     <= '0;
      cpu_reset   <= 1'b0;
      load_ok     <= 1'b0;
      load_err    <= 1'b0;
      sum         <= '0;
      word_cnt    <= '0;
      byte_idx    <= B0;
      addr_inc_p1 <= 1'b0;
    end else begin
      state       <= state_nxt;
      rx_ready    <= 1'b1;
      mem_we      <= wr_word;
      addr_inc_p1 <= wr_word && !last_word;
      if (wr_word) mem_din <= {b0_hold, b1_hold, rx_data};
      if (start) begin
        cpu_reset <= 1'b1;
        load_ok   <= 1'b0;
        load_err  <= 1'b0;
        sum       <= '0;
        word_cnt  <= '0;
        byte_idx  <= B0;
        mem_addr  <= '0;
      end else begin
        if (accept && (state != IDLE)) sum <= sum_nxt;
        if (accept && (state == DATA)) byte_idx <= (byte_idx == B2) ? B0 : byte_idx + 2'd1;
        if (wr_word) word_cnt <= word_cnt + 16'd1;
        // Address advances one cycle after the strobe so the write sees the old index.
        if (addr_inc_p1) mem_addr <= mem_addr + ADDR_W'(1);
      end
      if (len_bad || chk_bad || tmo_expire) load_err <= 1'b1;
      if (chk_good) begin
        load_ok   <= 1'b1;
        cpu_reset <= 1'b0;
      end
    end
  end

  // Stage p0: frame length and partial instruction bytes.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (state == LEN_HI) len_hi <= rx_data;
      if (state == LEN_LO) len <= len_full;
      if ((state == DATA) && (byte_idx == B0)) b0_hold <= rx_data[1:0];
      if ((state == DATA) && (byte_idx == B1)) b1_hold <= rx_data;
    end
  end

endmodule

// File: tb/tb_pb_prog_loader.sv
// Directed self-checking bench for pb_prog_loader with a 16-cycle inter-byte timeout.
module tb_pb_prog_loader;

  logic        clk;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [9:0]  mem_addr;
  logic [17:0] mem_din;
  logic        mem_we;
  logic        cpu_reset;
  logic        load_ok;
  logic        load_err;

  int n_assert = 0;
  int n_fail   = 0;

  logic [9:0]  wr_addr[$];
  logic [17:0] wr_data[$];

  pb_prog_loader #(
    .ADDR_W        (10),
    .SYNC_BYTE     (8'hA5),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_we   (mem_we),
    .cpu_reset(cpu_reset),
    .load_ok  (load_ok),
    .load_err (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_din);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic check_wr(input int idx, input logic [9:0] a, input logic [17:0] d);
    check("wr_addr", (idx < wr_addr.size()) ? wr_addr[idx] : 10'h3FF, a);
    check("wr_data", (idx < wr_data.size()) ? wr_data[idx] : 18'h00000, d);
  endtask

  task automatic check_reset_outputs();
    check("rst_rx_ready", rx_ready, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 10'h000);
    check("rst_mem_din", mem_din, 18'h00000);
    check("rst_cpu_reset", cpu_reset, 1'b0);
    check("rst_load_ok", load_ok, 1'b0);
    check("rst_load_err", load_err, 1'b0);
  endtask

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) tick();
    check_reset_outputs();
    reset = 1'b0;
    tick();
    check("rx_ready_after_reset", rx_ready, 1'b1);

    // Garbage then a good 2-word frame, checking write timing
    clear_log();
    send(8'h11);
    send(8'h22);
    check("garbage_cpu_reset", cpu_reset, 1'b0);
    check("garbage_no_write", wr_addr.size(), 0);
    send(8'hA5);
    check("sync_cpu_reset", cpu_reset, 1'b1);
    send(8'h00);
    send(8'h02);
    send(8'h00);
    send(8'h12);
    send(8'h34);
    check("w0_we", mem_we, 1'b1);
    check("w0_addr", mem_addr, 10'd0);
    check("w0_din", mem_din, 18'h01234);
    send(8'h03);
    check("w0_we_drop", mem_we, 1'b0);
    check("addr_inc", mem_addr, 10'd1);
    send(8'hFF);
    send(8'hFF);
    check("w1_we", mem_we, 1'b1);
    check("w1_addr", mem_addr, 10'd1);
    check("w1_din", mem_din, 18'h3FFFF);
    send(8'hB7);
    check("good_load_ok", load_ok, 1'b1);
    check("good_load_err", load_err, 1'b0);
    check("good_cpu_reset", cpu_reset, 1'b0);
    check("good_last_addr_hold", mem_addr, 10'd1);
    check("good_nwrites", wr_addr.size(), 2);
    check_wr(0, 10'd0, 18'h01234);
    check_wr(1, 10'd1, 18'h3FFFF);

    // Same frame with a bad checksum
    clear_log();
    send(8'hA5);
    check("bad_sync_clears_ok", load_ok, 1'b0);
    send(8'h00); send(8'h02);
    send(8'h00); send(8'h12); send(8'h34);
    send(8'h03); send(8'hFF); send(8'hFF);
    send(8'h00);
    check("badchk_load_err", load_err, 1'b1);
    check("badchk_load_ok", load_ok, 1'b0);
    check("badchk_cpu_reset", cpu_reset, 1'b1);
    check("badchk_nwrites", wr_addr.size(), 2);
    check_wr(0, 10'd0, 18'h01234);
    check_wr(1, 10'd1, 18'h3FFFF);

    // Length errors: LEN=0 and LEN=1025
    clear_log();
    send(8'hA5);
    check("len0_sync_clears_err", load_err, 1'b0);
    send(8'h00);
    send(8'h00);
    check("len0_load_err", load_err, 1'b1);
    send(8'hA5);
    check("len1025_sync_clears_err", load_err, 1'b0);
    send(8'h04);
    send(8'h01);
    check("len1025_load_err", load_err, 1'b1);
    repeat (3) tick();
    check("len_err_no_writes", wr_addr.size(), 0);

    // Timeout after the first data byte, then a good 1-word frame
    clear_log();
    send(8'hA5); send(8'h00); send(8'h01); send(8'h00);
    repeat (15) tick();
    check("tmo_not_yet", load_err, 1'b0);
    tick();
    check("tmo_load_err", load_err, 1'b1);
    check("tmo_cpu_reset", cpu_reset, 1'b1);
    send(8'hA5); send(8'h00); send(8'h01);
    send(8'hF3); send(8'hAB); send(8'hCD);
    send(8'h94);
    check("after_tmo_load_ok", load_ok, 1'b1);
    check("after_tmo_cpu_reset", cpu_reset, 1'b0);
    check("after_tmo_nwrites", wr_addr.size(), 1);
    check_wr(0, 10'd0, 18'h3ABCD);

    // Back-to-back 4-word frame with the sync byte used as data
    clear_log();
    send(8'hA5); send(8'h00); send(8'h04);
    send(8'hA5); send(8'h00); send(8'h01);
    send(8'h02); send(8'h03); send(8'h04);
    send(8'h01); send(8'hA5); send(8'hA5);
    send(8'h00); send(8'h00); send(8'h00);
    send(8'h02);
    check("b2b_load_ok", load_ok, 1'b1);
    check("b2b_nwrites", wr_addr.size(), 4);
    check_wr(0, 10'd0, 18'h10001);
    check_wr(1, 10'd1, 18'h20304);
    check_wr(2, 10'd2, 18'h1A5A5);
    check_wr(3, 10'd3, 18'h00000);

    // Reset in the middle of DATA, then reload from address 0
    send(8'hA5); send(8'h00); send(8'h02);
    send(8'h11); send(8'h22); send(8'h33);
    send(8'h44);
    check("mid_addr_before_reset", mem_addr, 10'd1);
    reset = 1'b1;
    tick();
    check_reset_outputs();
    reset = 1'b0;
    tick();
    clear_log();
    send(8'hA5); send(8'h00); send(8'h01);
    send(8'hF3); send(8'hAB); send(8'hCD);
    send(8'h94);
    check("reload_load_ok", load_ok, 1'b1);
    check("reload_cpu_reset", cpu_reset, 1'b0);
    check("reload_nwrites", wr_addr.size(), 1);
    check_wr(0, 10'd0, 18'h3ABCD);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
